// File: rtl/robot_motion_ctrl_pkg.sv
// Shared definitions for the wall-following robot motion sequencer.
// State encodings, manual command codes and a sizing helper.
package robot_motion_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_DECIDE = 3'd2,
    ST_MOVE   = 3'd3,
    ST_TURN   = 3'd4,
    ST_SETTLE = 3'd5
  } state_e;

  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_FWD  = 2'b01;
  localparam logic [1:0] CMD_TURN = 2'b10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/robot_motion_ctrl_timer.sv
// Loadable down-counter; done flags the last cycle of a timed state.
// Holds at zero when not reloaded.
module motion_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/robot_motion_ctrl.sv
// Motion sequencer: sample sensors, arbitrate manual vs navigation,
// drive timed motor pulses, then settle before the next step.
module robot_motion_ctrl
  import robot_motion_ctrl_pkg::*;
#(
  parameter int FWD_CYCLES    = 8,
  parameter int TURN_CYCLES   = 12,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             front_sensor,
  input  logic             left_sensor,
  input  logic             nav_front,
  input  logic             nav_turn,
  input  logic             man_req,
  input  logic [1:0]       man_cmd,
  output logic             front_q,
  output logic             left_q,
  output logic             sense_strobe,
  output logic             motor_fwd,
  output logic             motor_turn,
  output logic             man_ack,
  output logic             busy,
  output logic [CNT_W-1:0] step_count
);

  localparam int MAXC = max3(FWD_CYCLES, TURN_CYCLES, SETTLE_CYCLES);
  localparam int TW   = $clog2(MAXC + 1);

  state_e          r_state;
  state_e          w_nxt;
  logic            w_done;
  logic            w_load;
  logic [TW-1:0]   w_load_val;
  logic            w_act_end;

  logic             r_front;
  logic             r_left;
  logic             r_strobe;
  logic             r_fwd;
  logic             r_turn;
  logic             r_ack;
  logic             r_busy;
  logic [CNT_W-1:0] r_steps;

  motion_timer #(.W(TW)) u_timer (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_load  (w_load),
    .i_val   (w_load_val),
    .o_done  (w_done)
  );

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (enable) w_nxt = ST_SAMPLE;
      ST_SAMPLE: w_nxt = ST_DECIDE;
      ST_DECIDE: begin
        if (man_req) begin
          unique case (man_cmd)
            CMD_FWD:  w_nxt = ST_MOVE;
            CMD_TURN: w_nxt = ST_TURN;
            default:  w_nxt = ST_SETTLE;
          endcase
        end else if (nav_turn) begin
          w_nxt = ST_TURN;
        end else if (nav_front) begin
          w_nxt = ST_MOVE;
        end else begin
          w_nxt = ST_SETTLE;
        end
      end
      ST_MOVE, ST_TURN: if (w_done) w_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (w_done) w_nxt = enable ? ST_SAMPLE : ST_IDLE;
      end
      default:   w_nxt = ST_IDLE;
    endcase
  end

  // Timer reloads on every state change with the new state's length.
  always_comb begin
    w_load     = (w_nxt != r_state);
    w_load_val = TW'(1);
    unique case (w_nxt)
      ST_MOVE:   w_load_val = TW'(FWD_CYCLES);
      ST_TURN:   w_load_val = TW'(TURN_CYCLES);
      ST_SETTLE: w_load_val = TW'(SETTLE_CYCLES);
      default:   w_load_val = TW'(1);
    endcase
  end

  assign w_act_end = ((r_state == ST_MOVE) || (r_state == ST_TURN))
                     && (w_nxt == ST_SETTLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_front  <= 1'b0;
      r_left   <= 1'b0;
      r_strobe <= 1'b0;
      r_fwd    <= 1'b0;
      r_turn   <= 1'b0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
      r_steps  <= '0;
    end else begin
      r_state  <= w_nxt;
      r_strobe <= (w_nxt == ST_SAMPLE);
      r_fwd    <= (w_nxt == ST_MOVE);
      r_turn   <= (w_nxt == ST_TURN);
      r_busy   <= (w_nxt != ST_IDLE);
      r_ack    <= (r_state == ST_DECIDE) && man_req;
      if (w_nxt == ST_SAMPLE) begin
        r_front <= front_sensor;
        r_left  <= left_sensor;
      end
      if (w_act_end && (r_steps != '1)) begin
        r_steps <= r_steps + CNT_W'(1);
      end
    end
  end

  assign front_q      = r_front;
  assign left_q       = r_left;
  assign sense_strobe = r_strobe;
  assign motor_fwd    = r_fwd;
  assign motor_turn   = r_turn;
  assign man_ack      = r_ack;
  assign busy         = r_busy;
  assign step_count   = r_steps;

endmodule

// File: tb/tb_robot_motion_ctrl.sv
// Directed table-driven bench for robot_motion_ctrl.
// A second instance with CNT_W=2 covers step counter saturation.
module tb_robot_motion_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, enable, front_sensor, left_sensor;
  logic       nav_front, nav_turn, man_req;
  logic [1:0] man_cmd;

  logic        front_q, left_q, sense_strobe;
  logic        motor_fwd, motor_turn, man_ack, busy;
  logic [15:0] step_count;

  logic       s_front_q, s_left_q, s_strobe;
  logic       s_fwd, s_turn, s_ack, s_busy;
  logic [1:0] s_step;

  robot_motion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .front_sensor(front_sensor), .left_sensor(left_sensor),
    .nav_front(nav_front), .nav_turn(nav_turn),
    .man_req(man_req), .man_cmd(man_cmd),
    .front_q(front_q), .left_q(left_q),
    .sense_strobe(sense_strobe),
    .motor_fwd(motor_fwd), .motor_turn(motor_turn),
    .man_ack(man_ack), .busy(busy), .step_count(step_count)
  );

  robot_motion_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .front_sensor(front_sensor), .left_sensor(left_sensor),
    .nav_front(nav_front), .nav_turn(nav_turn),
    .man_req(man_req), .man_cmd(man_cmd),
    .front_q(s_front_q), .left_q(s_left_q),
    .sense_strobe(s_strobe),
    .motor_fwd(s_fwd), .motor_turn(s_turn),
    .man_ack(s_ack), .busy(s_busy), .step_count(s_step)
  );

  typedef struct {
    logic       fs;
    logic       ls;
    logic       nf;
    logic       nt;
    logic       mr;
    logic [1:0] mc;
    int         e_len;
    int         e_fwd;
    int         e_turn;
    int         e_ack;
    int         e_inc;
    int         e_first;
  } vec_t;

  vec_t vt[8];
  int   errors = 0;
  int   checks = 0;
  int   exp_steps;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts in a SAMPLE cycle; runs until the next strobe or a budget.
  task automatic run_step(output int len, output int nfwd,
                          output int nturn, output int nack,
                          output int nboth, output int first);
    len = 0; nfwd = 0; nturn = 0; nack = 0; nboth = 0; first = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (motor_fwd) nfwd++;
      if (motor_turn) nturn++;
      if (man_ack) nack++;
      if (motor_fwd && motor_turn) nboth++;
      if (first < 0 && (motor_fwd || motor_turn)) first = k;
      if (sense_strobe) begin
        len = k;
        break;
      end
    end
  endtask

  initial begin
    int len, nf, nt, na, nb, fi;
    int sf, ss, sb, sa;

    vt[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 12, 8, 0, 0, 1, 2};
    vt[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16, 0, 12, 0, 1, 2};
    vt[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 16, 0, 12, 0, 1, 2};
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4, 0, 0, 0, 0, -1};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 12, 8, 0, 1, 1, 2};
    vt[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 4, 0, 0, 1, 0, -1};
    vt[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 4, 0, 0, 1, 0, -1};
    vt[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 16, 0, 12, 1, 1, 2};

    rst_n = 1'b0; enable = 1'b0;
    front_sensor = 1'b0; left_sensor = 1'b0;
    nav_front = 1'b0; nav_turn = 1'b0;
    man_req = 1'b0; man_cmd = 2'b00;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_motors", motor_fwd | motor_turn, 0);
    chk("rst_steps", step_count, 0);
    chk("rst_strobe_ack", sense_strobe | man_ack, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    exp_steps = 0;
    enable = 1'b1;
    tick();
    chk("first_strobe", sense_strobe, 1);
    chk("first_busy", busy, 1);

    for (int i = 0; i < 8; i++) begin
      front_sensor = vt[i].fs; left_sensor = vt[i].ls;
      nav_front = vt[i].nf; nav_turn = vt[i].nt;
      man_req = vt[i].mr; man_cmd = vt[i].mc;
      run_step(len, nf, nt, na, nb, fi);
      exp_steps += vt[i].e_inc;
      chk($sformatf("v%0d_len", i), len, vt[i].e_len);
      chk($sformatf("v%0d_fwd", i), nf, vt[i].e_fwd);
      chk($sformatf("v%0d_turn", i), nt, vt[i].e_turn);
      chk($sformatf("v%0d_ack", i), na, vt[i].e_ack);
      chk($sformatf("v%0d_both", i), nb, 0);
      chk($sformatf("v%0d_first", i), fi, vt[i].e_first);
      chk($sformatf("v%0d_steps", i), step_count, exp_steps);
      chk($sformatf("v%0d_front_q", i), front_q, vt[i].fs);
      chk($sformatf("v%0d_left_q", i), left_q, vt[i].ls);
    end

    // Reset while turning.
    man_req = 1'b0; nav_front = 1'b0; nav_turn = 1'b1;
    tick(); tick(); tick(); tick();
    chk("pre_rst_turn", motor_turn, 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_turn", motor_turn, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_steps", step_count, 0);
    chk("midrst_q", {30'd0, front_q, left_q}, 0);
    chk("midrst_sat_steps", s_step, 0);
    rst_n = 1'b1; enable = 1'b0; nav_turn = 1'b0;
    tick(); tick();
    chk("post_rst_idle", busy | sense_strobe, 0);

    // Saturation on the 2-bit instance.
    exp_steps = 0;
    enable = 1'b1; nav_front = 1'b1;
    tick();
    chk("sat_strobe", sense_strobe, 1);
    for (int i = 0; i < 5; i++) begin
      run_step(len, nf, nt, na, nb, fi);
      exp_steps++;
      chk($sformatf("sat%0d_count", i), s_step, (i + 1 > 3) ? 3 : i + 1);
      chk($sformatf("sat%0d_main", i), step_count, exp_steps);
    end

    // Graceful stop: enable dropped in the third MOVE cycle.
    nf = 0; ss = 0; sb = 0; sa = 0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      if (motor_fwd) nf++;
    end
    enable = 1'b0;
    sf = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (motor_fwd) nf++;
      if (busy && !motor_fwd && !motor_turn) ss++;
      if (sense_strobe) sb++;
      if (man_ack) sa++;
      if (!busy) begin
        sf = 1;
        break;
      end
    end
    exp_steps++;
    chk("stop_reached_idle", sf, 1);
    chk("stop_fwd_total", nf, 8);
    chk("stop_settle", ss, 2);
    chk("stop_no_strobe", sb, 0);
    chk("stop_no_ack", sa, 0);
    chk("stop_steps", step_count, exp_steps);
    sb = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (busy || sense_strobe) sb++;
    end
    chk("stop_parked", sb, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
